// File: rtl/data_ram_mbox_pkg.sv
// Shared defaults and status-word layout for the data RAM with key mailbox.
package data_ram_mbox_pkg;
  localparam int          DATA_W_DEF    = 32;
  localparam int          ADDR_W_DEF    = 13;
  localparam logic [12:0] MBOX_ADDR_DEF = 13'h0310;
  localparam int          STAT_OVF_BIT  = 31;
  localparam int          STAT_CNT_MSB  = 7;
  localparam int          STAT_CNT_W    = STAT_CNT_MSB + 1;
endpackage

// File: rtl/data_ram_mbox_key_fifo.sv
// Keyboard mailbox FIFO: push from scanner, pop on CPU mailbox read,
// empty-FIFO bypass and sticky overflow.
module key_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_req,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              overflow
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic              empty;
  logic              full;
  logic              do_push;
  logic              do_pop;
  logic              ovf_set;

  // A push meeting a pop on an empty FIFO is forwarded, never stored.
  always_comb begin
    empty   = count == '0;
    full    = count == CW'(DEPTH);
    do_pop  = pop_req & ~empty;
    do_push = push & (~full | do_pop) & ~(empty & pop_req);
    ovf_set = push & full & ~do_pop;
    rd_data = '0;
    if (pop_req) begin
      if (!empty)   rd_data = mem[head];
      else if (push) rd_data = push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && do_push) mem[tail] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      count    <= count + CW'(do_push) - CW'(do_pop);
      overflow <= ovf_set | (overflow & ~clr_ovf);
    end
  end
endmodule

// File: rtl/data_ram_mbox.sv
// Byte-enabled data RAM with optional key mailbox + status word.
// Mailbox present only when KEY_MAILBOX_EN is defined.
module data_ram_mbox
  import data_ram_mbox_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_DEF,
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                DEPTH      = 2048,
  parameter logic [ADDR_W-1:0] MBOX_ADDR  = ADDR_W'(MBOX_ADDR_DEF),
  parameter int                MBOX_DEPTH = 4,
  parameter string             INIT_FILE  = "ram8x2048.mif"
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   ram_addr,
  input  logic                ram_write_enable,
  input  logic [DATA_W/8-1:0] ram_byte_en,
  input  logic [DATA_W-1:0]   ram_write_data,
  output logic [DATA_W-1:0]   ram_read_data,
  input  logic [DATA_W-1:0]   key_ram_wdata,
  input  logic                key_ram_wen
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-3:0] waddr;
  logic [IDX_W-1:0]  idx;
  logic              is_reg;
  logic [DATA_W-1:0] reg_rd;
  logic              unused_lo;

  assign waddr     = ram_addr[ADDR_W-1:2];
  assign idx       = IDX_W'(int'(waddr) % DEPTH);
  assign unused_lo = ^ram_addr[1:0];

`ifdef KEY_MAILBOX_EN
  localparam logic [ADDR_W-1:0] STAT_ADDR = MBOX_ADDR + ADDR_W'(4);
  localparam int CNT_W = $clog2(MBOX_DEPTH) + 1;

  logic             is_mbox;
  logic             is_stat;
  logic             pop_req;
  logic             clr_ovf;
  logic             overflow;
  logic [CNT_W-1:0] count;
  logic [DATA_W-1:0] fifo_rd;

  assign is_mbox = waddr == MBOX_ADDR[ADDR_W-1:2];
  assign is_stat = waddr == STAT_ADDR[ADDR_W-1:2];
  assign is_reg  = is_mbox | is_stat;
  assign pop_req = is_mbox & ~ram_write_enable;
  assign clr_ovf = is_stat & ~ram_write_enable;

  key_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (MBOX_DEPTH)
  ) u_key_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (key_ram_wen),
    .push_data(key_ram_wdata),
    .pop_req  (pop_req),
    .clr_ovf  (clr_ovf),
    .rd_data  (fifo_rd),
    .count    (count),
    .overflow (overflow)
  );

  always_comb begin
    reg_rd = '0;
    if (clr_ovf) begin
      reg_rd[STAT_OVF_BIT]     = overflow;
      reg_rd[STAT_CNT_MSB:0]   = STAT_CNT_W'(count);
    end else if (pop_req) begin
      reg_rd = fifo_rd;
    end
  end
`else
  logic unused_keys;

  assign is_reg      = 1'b0;
  assign reg_rd      = '0;
  assign unused_keys = ^{key_ram_wdata, key_ram_wen};
`endif

  always_ff @(posedge clock) begin
    if (!reset && ram_write_enable && !is_reg) begin
      for (int i = 0; i < NB; i++) begin
        if (ram_byte_en[i]) mem[idx][8*i +: 8] <= ram_write_data[8*i +: 8];
      end
    end
  end

  // Read samples the array before this edge's write: old data on collision.
  always_ff @(posedge clock) begin
    if (reset)       ram_read_data <= '0;
    else if (is_reg) ram_read_data <= reg_rd;
    else             ram_read_data <= mem[idx];
  end
endmodule

// File: tb/tb_data_ram_mbox.sv
// Bench for data_ram_mbox: directed vector table plus random ops
// against a queue/array reference model.
module tb_data_ram_mbox;
  localparam logic [12:0] MB = 13'h0310;
  localparam logic [12:0] ST = 13'h0314;

  logic        clock = 1'b0;
  logic        reset;
  logic [12:0] ram_addr;
  logic        ram_write_enable;
  logic [3:0]  ram_byte_en;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic [31:0] key_ram_wdata;
  logic        key_ram_wen;

  always #5 clock = ~clock;

  data_ram_mbox dut (
    .clock           (clock),
    .reset           (reset),
    .ram_addr        (ram_addr),
    .ram_write_enable(ram_write_enable),
    .ram_byte_en     (ram_byte_en),
    .ram_write_data  (ram_write_data),
    .ram_read_data   (ram_read_data),
    .key_ram_wdata   (key_ram_wdata),
    .key_ram_wen     (key_ram_wen)
  );

  typedef struct {
    bit          rst;
    bit          we;
    logic [12:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          kw;
    logic [31:0] kd;
    bit          chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] ram_m [2048];
  bit          known [2048];
  logic [31:0] q[$];
  bit          ovf = 0;

  function automatic void add(bit rst, bit we, logic [12:0] a,
                              logic [3:0] be, logic [31:0] wd, bit kw,
                              logic [31:0] kd, bit chk, logic [31:0] exp,
                              string nm);
    vec_t v;
    v.rst = rst; v.we = we; v.addr = a; v.be = be; v.wd = wd;
    v.kw = kw; v.kd = kd; v.chk = chk; v.exp = exp; v.name = nm;
    vecs.push_back(v);
  endfunction

  function automatic void wr(logic [12:0] a, logic [3:0] be, logic [31:0] d);
    add(0, 1, a, be, d, 0, 0, 0, 0, "wr");
  endfunction

  function automatic void rd(logic [12:0] a, logic [31:0] e, string nm);
    add(0, 0, a, 4'h0, 0, 0, 0, 1, e, nm);
  endfunction

  function automatic void push(logic [31:0] k);
    add(0, 0, 13'h0040, 4'h0, 0, 1, k, 0, 0, "push");
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference behaviour evaluated at each rising edge.
  task automatic model_edge(input vec_t v, output logic [31:0] e,
                            output bit ek);
    int idx;
    int n;
    bit is_m;
    bit is_s;
    bit popped;
    bit byp;
    bit ovf_set;
    idx = int'(v.addr[12:2]) % 2048;
    e   = '0;
    ek  = 1;
    if (v.rst) begin
      q.delete();
      ovf = 0;
      return;
    end
`ifdef KEY_MAILBOX_EN
    is_m = v.addr[12:2] == MB[12:2];
    is_s = v.addr[12:2] == ST[12:2];
`else
    is_m = 0;
    is_s = 0;
`endif
    n = q.size();
    popped = 0; byp = 0; ovf_set = 0;
    if (is_m) begin
      if (!v.we) begin
        if (n > 0) begin
          e = q.pop_front();
          popped = 1;
        end else if (v.kw) begin
          e = v.kd;
          byp = 1;
        end
      end
    end else if (is_s) begin
      if (!v.we) e = {ovf, 23'd0, 8'(n)};
    end else begin
      e  = ram_m[idx];
      ek = known[idx];
      if (v.we) begin
        for (int i = 0; i < 4; i++)
          if (v.be[i]) ram_m[idx][8*i +: 8] = v.wd[8*i +: 8];
        if (v.be == 4'hF) known[idx] = 1;
      end
    end
`ifdef KEY_MAILBOX_EN
    if (v.kw && !byp) begin
      if (n < 4 || popped) q.push_back(v.kd);
      else ovf_set = 1;
    end
    if (is_s && !v.we) ovf = ovf_set;
    else ovf = ovf | ovf_set;
`endif
  endtask

  task automatic step(input vec_t v, input bit rnd);
    logic [31:0] e;
    bit          ek;
    reset            = v.rst;
    ram_write_enable = v.we;
    ram_addr         = v.addr;
    ram_byte_en      = v.be;
    ram_write_data   = v.wd;
    key_ram_wen      = v.kw;
    key_ram_wdata    = v.kd;
    @(posedge clock);
    model_edge(v, e, ek);
    #1;
    if (v.chk) check(v.name, ram_read_data, v.exp);
    if (rnd && ek) check("rand", ram_read_data, e);
  endtask

  initial begin
    vec_t v;
    int   r;
    reset = 1; ram_addr = '0; ram_write_enable = 0; ram_byte_en = '0;
    ram_write_data = '0; key_ram_wen = 0; key_ram_wdata = '0;

    add(1, 0, 13'h0, 4'h0, 0, 0, 0, 1, 32'h0, "reset_out");
    add(1, 0, 13'h0, 4'h0, 0, 0, 0, 1, 32'h0, "reset_hold");
    wr(13'h0040, 4'hF, 32'hDEADBEEF);
    wr(13'h0040, 4'h2, 32'h0000AA00);
    rd(13'h0040, 32'hDEADAAEF, "byte_en");
    rd(13'h0042, 32'hDEADAAEF, "addr_lowbits");
    wr(13'h0044, 4'hF, 32'h11111111);
    add(0, 1, 13'h0044, 4'hF, 32'h22222222, 0, 0, 1, 32'h11111111, "rdw_old");
    rd(13'h0044, 32'h22222222, "rdw_new");
    add(1, 1, 13'h0040, 4'hF, 32'h0, 0, 0, 1, 32'h0, "rst_wr_out");
    rd(13'h0040, 32'hDEADAAEF, "rst_wr_ignored");
`ifdef KEY_MAILBOX_EN
    push(32'h41); push(32'h42);
    rd(MB, 32'h41, "pop1");
    rd(MB, 32'h42, "pop2");
    rd(MB, 32'h0, "pop_empty");
    rd(ST, 32'h0, "stat_cnt0");
    for (int k = 0; k < 5; k++) push(32'h61 + k);
    rd(ST, 32'h80000004, "ovf_set");
    rd(ST, 32'h00000004, "ovf_clr");
    for (int k = 0; k < 4; k++) rd(MB, 32'h61 + k, "drain_ovf");
    add(0, 0, MB, 4'h0, 0, 1, 32'h5A, 1, 32'h5A, "bypass");
    rd(ST, 32'h0, "bypass_cnt");
    push(32'h70);
    add(0, 0, MB, 4'h0, 0, 1, 32'h71, 1, 32'h70, "pushpop");
    rd(ST, 32'h1, "pushpop_cnt");
    rd(MB, 32'h71, "pushpop_tail");
    for (int k = 1; k <= 4; k++) push(k);
    add(0, 0, ST, 4'h0, 0, 1, 32'h5, 1, 32'h00000004, "ovf_race_old");
    rd(ST, 32'h80000004, "ovf_race_keep");
    rd(ST, 32'h00000004, "ovf_race_clr");
    for (int k = 1; k <= 4; k++) rd(MB, k, "drain_race");
    for (int k = 0; k < 4; k++) push(32'hA0 + k);
    add(0, 0, MB, 4'h0, 0, 1, 32'hA4, 1, 32'hA0, "full_pushpop");
    rd(ST, 32'h4, "full_pushpop_cnt");
    for (int k = 1; k <= 4; k++) rd(MB, 32'hA0 + k, "drain_full");
    wr(MB, 4'hF, 32'hFFFFFFFF);
    wr(ST, 4'hF, 32'hFFFFFFFF);
    rd(ST, 32'h0, "reg_wr_ign");
    rd(MB, 32'h0, "reg_wr_ign_mb");
    push(32'h31); push(32'h32); push(32'h33);
    add(1, 0, 13'h0040, 4'h0, 0, 1, 32'h34, 1, 32'h0, "rst_mid");
    rd(MB, 32'h0, "rst_pop");
    rd(ST, 32'h0, "rst_stat");
    rd(13'h0040, 32'hDEADAAEF, "rst_ram");
`else
    wr(MB, 4'hF, 32'h12345678);
    add(0, 0, MB, 4'h0, 0, 1, 32'h99, 1, 32'h12345678, "no_mbox");
    wr(ST, 4'hF, 32'hCAFE0000);
    add(0, 0, ST, 4'h0, 0, 1, 32'h77, 1, 32'hCAFE0000, "no_stat");
`endif

    foreach (vecs[i]) step(vecs[i], 0);

    for (int i = 0; i < 16; i++) begin
      v = vecs[0];
      v.rst = 0; v.we = 1; v.addr = 13'h0200 + 13'(4 * i);
      v.be = 4'hF; v.wd = $urandom; v.kw = 0; v.chk = 0;
      step(v, 1);
    end
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      v = vecs[0];
      v.rst  = 0;
      v.chk  = 0;
      v.we   = 0;
      v.be   = 4'h0;
      v.wd   = $urandom;
      v.addr = 13'h0200 + 13'(4 * $urandom_range(0, 15))
             + 13'($urandom_range(0, 3));
      v.kw   = $urandom_range(0, 2) == 0;
      v.kd   = $urandom;
      if (r < 30) begin
        v.we = 1;
        v.be = 4'($urandom_range(0, 15));
      end else if (r < 55) begin
        v.addr = MB;
      end else if (r < 70) begin
        v.addr = ST;
      end else if (r < 72) begin
        v.rst = 1;
      end
      step(v, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_ram_mbox.md
DATA_RAM_MBOX -- requirements
Module: data_ram_mbox

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; multiple of 8.
REQ-002 Parameter ADDR_W, default 13, byte-address width.
REQ-003 Parameter DEPTH, default 2048, RAM depth in words; DEPTH <= 2**(ADDR_W-2).
REQ-004 Parameter MBOX_ADDR, default 13'h0310, byte address of the key mailbox data word; word-aligned.
REQ-005 Parameter MBOX_DEPTH, default 4, key FIFO entries; power of two, >= 2.
REQ-006 Parameter INIT_FILE, default "ram8x2048.mif", RAM init image.
REQ-007 clock  in  1  sole clock; all state updates on rising edge.
REQ-008 reset  in  1  reset, synchronous and active-high.
REQ-009 ram_addr  in  ADDR_W  CPU byte address; bits [1:0] ignored.
REQ-010 ram_write_enable  in  1  CPU write strobe.
REQ-011 ram_byte_en  in  DATA_W/8  per-byte write enables.
REQ-012 ram_write_data  in  DATA_W  CPU write data.
REQ-013 ram_read_data  out  DATA_W  registered read data.
REQ-014 key_ram_wdata  in  DATA_W  key code from keyboard scanner.
REQ-015 key_ram_wen  in  1  one-cycle key push strobe.

Function
REQ-016 Read latency exactly 1 cycle: ram_read_data reflects the address presented in the previous cycle.
REQ-017 RAM word index = ram_addr[ADDR_W-1:2] modulo DEPTH (wrap-around beyond DEPTH).
REQ-018 RAM write: when ram_write_enable=1, only bytes with ram_byte_en[i]=1 are updated.
REQ-019 Read-during-write to the same word returns the old (pre-write) contents.
REQ-020 Status word at MBOX_ADDR+4: bit 31 = sticky overflow, bits [7:0] = FIFO count; other bits 0.
REQ-021 Mailbox and status addresses never access RAM; CPU writes to them are ignored.
REQ-022 Push: key_ram_wen=1 and FIFO not full enqueues key_ram_wdata at tail.
REQ-023 Push when full: data dropped, overflow flag set, FIFO unchanged.
REQ-024 Pop: CPU read (ram_write_enable=0) of MBOX_ADDR with FIFO non-empty returns head next cycle and dequeues it.
REQ-025 Read of MBOX_ADDR with FIFO empty and no push returns 0, no state change.
REQ-026 Simultaneous push and pop on non-empty FIFO: both performed, count unchanged.
REQ-027 Simultaneous push and pop on empty FIFO: pushed word bypassed to ram_read_data, FIFO remains empty.
REQ-028 Read of status word clears overflow flag after returning it; an overflow in the same cycle keeps the flag set.
REQ-029 Head/tail pointers wrap modulo MBOX_DEPTH; count range 0..MBOX_DEPTH.

Reset
REQ-030 On reset: FIFO count, pointers, overflow cleared; ram_read_data = 0 the cycle after reset asserts.
REQ-031 Reset does not alter RAM contents; CPU writes and key pushes during reset are ignored.
REQ-032 Reset asserted mid-sequence discards any pending pop; first read after deassert behaves as from empty FIFO.

Configuration
REQ-033 Macro KEY_MAILBOX_EN: defined -> mailbox FIFO and status word present per REQ-020..029.
REQ-034 KEY_MAILBOX_EN undefined -> no FIFO; MBOX_ADDR and MBOX_ADDR+4 are ordinary RAM words; key_ram_wdata/key_ram_wen ignored.

Structure
REQ-035 Shared package holds MBOX_ADDR default, status-word bit positions, and default DATA_W/ADDR_W.
REQ-036 One sub-module key_fifo (push/pop/count/overflow) instantiated only under KEY_MAILBOX_EN; RAM array inferred in the top module.

Verification
REQ-037 Write 32'hDEADBEEF to 0x0040 byte_en=4'b1111, then byte_en=4'b0010 data 32'h0000AA00; read 0x0040 -> 32'hDEADAAEF one cycle later.
REQ-038 Push 0x41,0x42; read MBOX_ADDR twice -> 0x41 then 0x42; third read -> 0; status count 0.
REQ-039 Push 5 keys into MBOX_DEPTH=4 -> status 32'h80000004; status re-read -> 32'h00000004.
REQ-040 Empty FIFO, push 0x5A same cycle as mailbox read -> returns 0x5A; next status read count 0.
REQ-041 Push 3 keys, assert reset one cycle, read MBOX_ADDR -> 0, status 0; RAM word 0x0040 still 32'hDEADAAEF.
REQ-042 Build without KEY_MAILBOX_EN: write 32'h12345678 to MBOX_ADDR, push key -> read returns 32'h12345678.
